// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM state encoding for the handshaked ALU.
// The MUL state exists only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_CMP = 2'b11;

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DONE = 2'd2
   } state_t;
`endif

endpackage

// File: rtl/alu_seq_if.sv
// Operand/op input handshake and result output handshake of alu_seq.
interface alu_seq_if #(parameter int WIDTH = 5);
   // A transfer happens on a rising edge where valid and ready are both high.
   // The producer holds its payload stable while valid is high and ready is low;
   // ready never depends on valid in the same cycle.
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       S;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] F;
   logic             Overflow;
   logic             Cout;

   modport master (
      output in_valid, S, X, Y, out_ready,
      input  in_ready, out_valid, F, Overflow, Cout
   );

   modport slave (
      input  in_valid, S, X, Y, out_ready,
      output in_ready, out_valid, F, Overflow, Cout
   );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per step.
// product is the accumulator including the current step, so it is final when done is high.
module alu_seq_mul #(
   parameter int WIDTH = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;

   always_comb begin
      product = acc + (mplier[0] ? mcand : '0);
   end

   assign done = step && (count == CW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         count  <= '0;
      end else if (start) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         count  <= CW'(WIDTH);
      end else if (step && (count != '0)) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - CW'(1);
      end
   end
endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: ADD/SUB/CMP in one cycle, MUL iterative when ALU_SEQ_MUL_EN is defined
// (otherwise S=10 is a one-cycle bitwise AND). Results are held until out_ready.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.slave  bus,
   output state_t    dbg_state
);
   localparam int MSB = WIDTH - 1;

   state_t           state;
   logic [WIDTH-1:0] f_q;
   logic             ovf_q;
   logic             cout_q;
   logic             valid_q;

   logic             accept;
   logic             mul_sel;
   logic             is_sub;
   logic [WIDTH-1:0] y_op;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] f_n;
   logic             ovf_n;
   logic             cout_n;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = valid_q;
   assign bus.F         = f_q;
   assign bus.Overflow  = ovf_q;
   assign bus.Cout      = cout_q;
   assign dbg_state     = state;

   assign accept = bus.in_valid & bus.in_ready;

`ifdef ALU_SEQ_MUL_EN
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   assign mul_sel = (bus.S == OP_MUL);

   alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && mul_sel),
      .step    (state == MUL),
      .a       (bus.X),
      .b       (bus.Y),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   assign mul_sel = 1'b0;
`endif

   // SUB reuses the adder as X + ~Y + 1, so Cout=1 means no borrow.
   always_comb begin
      is_sub = (bus.S == OP_SUB);
      y_op   = is_sub ? ~bus.Y : bus.Y;
      sum    = {1'b0, bus.X} + {1'b0, y_op} + {{WIDTH{1'b0}}, is_sub};
      f_n    = sum[MSB:0];
      cout_n = sum[WIDTH];
      ovf_n  = 1'b0;
      case (bus.S)
         OP_ADD: ovf_n = (bus.X[MSB] == bus.Y[MSB]) && (sum[MSB] != bus.X[MSB]);
         OP_SUB: ovf_n = (bus.X[MSB] != bus.Y[MSB]) && (sum[MSB] != bus.X[MSB]);
         OP_CMP: begin
            f_n    = {{(WIDTH-1){1'b0}}, ($signed(bus.X) < $signed(bus.Y))};
            cout_n = (bus.X < bus.Y);
         end
         default: begin
`ifdef ALU_SEQ_MUL_EN
            f_n    = '0;
`else
            f_n    = bus.X & bus.Y;
`endif
            cout_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         f_q     <= '0;
         ovf_q   <= 1'b0;
         cout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (mul_sel) begin
                     state <= DONE;
`ifdef ALU_SEQ_MUL_EN
                     state <= MUL;
`endif
                  end else begin
                     f_q     <= f_n;
                     ovf_q   <= ovf_n;
                     cout_q  <= cout_n;
                     valid_q <= 1'b1;
                     state   <= DONE;
                  end
               end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
               if (mul_done) begin
                  f_q     <= mul_product[MSB:0];
                  ovf_q   <= |mul_product[2*WIDTH-1:WIDTH];
                  cout_q  <= 1'b0;
                  valid_q <= 1'b1;
                  state   <= DONE;
               end
            end
`endif
            DONE: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=5); MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic   clk;
   logic   rst;
   state_t dbg_state;
   int     n_vec;
   int     n_err;

   alu_seq_if #(.WIDTH(5)) bus ();

   alu_seq #(.WIDTH(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one op for exactly one rising edge, then scrambles X/Y; returns at the next falling edge.
   task automatic apply(input logic [1:0] s, input logic [4:0] x, input logic [4:0] y);
      bus.in_valid = 1'b1;
      bus.S        = s;
      bus.X        = x;
      bus.Y        = y;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.X        = 5'($urandom_range(0, 31));
      bus.Y        = 5'($urandom_range(0, 31));
      bus.S        = 2'($urandom_range(0, 3));
      @(negedge clk);
   endtask

   task automatic check_result(input string tag, input logic [4:0] f, input logic ovf, input logic cout);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_F"},     32'(bus.F),         32'(f));
      check({tag, "_ovf"},   32'(bus.Overflow),  32'(ovf));
      check({tag, "_cout"},  32'(bus.Cout),      32'(cout));
      check({tag, "_ready"}, 32'(bus.in_ready),  32'd0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_idle_ready"}, 32'(bus.in_ready),  32'd1);
   endtask

   initial begin
      n_vec         = 0;
      n_err         = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.S         = 2'b00;
      bus.X         = 5'd0;
      bus.Y         = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // reset state
      check("rst_ready", 32'(bus.in_ready),  32'd1);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_F",     32'(bus.F),         32'd0);
      check("rst_ovf",   32'(bus.Overflow),  32'd0);
      check("rst_cout",  32'(bus.Cout),      32'd0);
      check("rst_state", 32'(dbg_state),     32'(IDLE));

      // ADD 7+7 = 14, out_valid for exactly one cycle
      apply(OP_ADD, 5'b00111, 5'b00111);
      check_result("add_7_7", 5'b01110, 1'b0, 1'b0);
      @(negedge clk);
      check_idle("add_7_7");

      // ADD 15+7 = 22: positive overflow
      apply(OP_ADD, 5'b01111, 5'b00111);
      check_result("add_15_7", 5'b10110, 1'b1, 1'b0);
      @(negedge clk);

      // ADD with carry out: 11000 + 01000 = 1_00000
      apply(OP_ADD, 5'b11000, 5'b01000);
      check_result("add_carry", 5'b00000, 1'b0, 1'b1);
      @(negedge clk);

      // SUB 3-9 = -6 with borrow, then 3-1 = 2 without
      apply(OP_SUB, 5'b00011, 5'b01001);
      check_result("sub_3_9", 5'b11010, 1'b0, 1'b0);
      @(negedge clk);
      apply(OP_SUB, 5'b00011, 5'b00001);
      check_result("sub_3_1", 5'b00010, 1'b0, 1'b1);
      @(negedge clk);

      // SUB 01000 - 11000 (8 - -8 = 16): signed overflow, borrow
      apply(OP_SUB, 5'b01000, 5'b11000);
      check_result("sub_ovf", 5'b10000, 1'b1, 1'b0);
      @(negedge clk);

      // CMP 3 vs 10001: not less signed, less unsigned
      apply(OP_CMP, 5'b00011, 5'b10001);
      check_result("cmp_3_m15", 5'b00000, 1'b0, 1'b1);
      @(negedge clk);
      // CMP 10001 vs 00011: less signed, not less unsigned
      apply(OP_CMP, 5'b10001, 5'b00011);
      check_result("cmp_m15_3", 5'b00001, 1'b0, 1'b0);
      @(negedge clk);

`ifdef ALU_SEQ_MUL_EN
      // MUL 15*15 = 225: out_valid exactly 5 cycles after accept
      apply(OP_MUL, 5'b01111, 5'b01111);
      for (int i = 0; i < 4; i++) begin
         check("mul_busy_valid", 32'(bus.out_valid), 32'd0);
         check("mul_busy_ready", 32'(bus.in_ready),  32'd0);
         @(negedge clk);
      end
      check("mul_busy_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check_result("mul_15_15", 5'b00001, 1'b1, 1'b0);
      @(negedge clk);
      check_idle("mul_15_15");
`else
      // S=10 without the multiplier is a one-cycle AND
      apply(OP_MUL, 5'b01111, 5'b01111);
      check_result("and_15_15", 5'b01111, 1'b0, 1'b0);
      @(negedge clk);
      apply(OP_MUL, 5'b10110, 5'b01101);
      check_result("and_mix", 5'b00100, 1'b0, 1'b0);
      @(negedge clk);
`endif

      // Backpressure: ADD 10+12 = 22 held for 4 cycles while a competing op waits
      bus.out_ready = 1'b0;
      apply(OP_ADD, 5'b01010, 5'b01100);
      bus.in_valid = 1'b1;
      bus.S        = OP_SUB;
      bus.X        = 5'b00001;
      bus.Y        = 5'b00001;
      for (int i = 0; i < 4; i++) begin
         check_result("hold", 5'b10110, 1'b1, 1'b0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      // the handoff edge must not also accept the pending op
      check_idle("handoff");
      bus.in_valid = 1'b0;
      @(negedge clk);

`ifdef ALU_SEQ_MUL_EN
      // Reset two steps into a multiply
      apply(OP_MUL, 5'b01111, 5'b01111);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
`else
      // Reset while a result is held
      bus.out_ready = 1'b0;
      apply(OP_ADD, 5'b01010, 5'b01100);
      rst = 1'b1;
`endif
      @(negedge clk);
      check("abort_ready", 32'(bus.in_ready),  32'd1);
      check("abort_valid", 32'(bus.out_valid), 32'd0);
      check("abort_F",     32'(bus.F),         32'd0);
      check("abort_state", 32'(dbg_state),     32'(IDLE));
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);

      apply(OP_ADD, 5'b00011, 5'b00100);
      check_result("post_rst_add", 5'b00111, 1'b0, 1'b0);
      @(negedge clk);

`ifdef ALU_SEQ_MUL_EN
      // full-length multiply after the abort: 3*5 = 15
      apply(OP_MUL, 5'b00011, 5'b00101);
      repeat (4) @(negedge clk);
      check("post_rst_mul_early", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check_result("post_rst_mul", 5'b01111, 1'b0, 1'b0);
      @(negedge clk);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
